// File: rtl/kamus_mem.sv
// rtl/kamus_mem.sv - kamus memory-access stage: L1D request/grant/rvalid, store lanes, load extend.
// Optional KAMUS_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of reaching L1D.
module kamus_mem (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [5:0]  operation_i,
   input  logic [31:0] ex_i,
   input  logic [31:0] rs2_data_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        l1d_wr_en_i,
   input  logic        regfile_wr_en_i,
   input  logic [1:0]  wb_mux_sel_i,
   output logic        l1d_req_o,
   output logic        l1d_we_o,
   output logic [31:0] l1d_addr_o,
   output logic [3:0]  l1d_be_o,
   output logic [31:0] l1d_wdata_o,
   input  logic        l1d_gnt_i,
   input  logic        l1d_rvalid_i,
   input  logic [31:0] l1d_rdata_i,
   output logic        valid_o,
   output logic [31:0] ex_o,
   output logic [31:0] load_data_o,
   output logic [4:0]  rd_addr_o,
   output logic        regfile_wr_en_o,
   output logic [1:0]  wb_mux_sel_o,
   output logic        misaligned_o
);

   localparam logic [5:0] OP_LB  = 6'd1;
   localparam logic [5:0] OP_LBU = 6'd2;
   localparam logic [5:0] OP_LH  = 6'd3;
   localparam logic [5:0] OP_LHU = 6'd4;
   localparam logic [5:0] OP_LW  = 6'd5;
   localparam logic [5:0] OP_SB  = 6'd6;
   localparam logic [5:0] OP_SH  = 6'd7;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [31:0] ex_q, ex_d, rs2_q, rs2_d;
   logic [4:0]  rd_q, rd_d;
   logic        st_q, st_d, rf_q, rf_d;
   logic [1:0]  sel_q, sel_d;

   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;

   logic        valid_q, valid_d, wb_rf_q, wb_rf_d, mis_q, mis_d;
   logic [31:0] wb_ex_q, wb_ex_d, ld_q, ld_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [1:0]  wb_sel_q, wb_sel_d;

   logic [5:0]  cur_op;
   logic [31:0] cur_ex, cur_rs2, shifted, ext;
   logic [4:0]  cur_rd;
   logic        cur_st, cur_rf;
   logic [1:0]  cur_sel, a;
   logic [15:0] half_v;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic        is_load, is_byte, is_half, is_mem, mis, done;

   always_comb begin
      // In IDLE the instruction being accepted is still on the inputs.
      cur_op  = (state_q == IDLE) ? operation_i     : op_q;
      cur_ex  = (state_q == IDLE) ? ex_i            : ex_q;
      cur_rs2 = (state_q == IDLE) ? rs2_data_i      : rs2_q;
      cur_rd  = (state_q == IDLE) ? rd_addr_i       : rd_q;
      cur_st  = (state_q == IDLE) ? l1d_wr_en_i     : st_q;
      cur_rf  = (state_q == IDLE) ? regfile_wr_en_i : rf_q;
      cur_sel = (state_q == IDLE) ? wb_mux_sel_i    : sel_q;
      a       = cur_ex[1:0];

      is_load = (cur_op == OP_LB) || (cur_op == OP_LBU) || (cur_op == OP_LH) ||
                (cur_op == OP_LHU) || (cur_op == OP_LW);
      is_byte = (cur_op == OP_LB) || (cur_op == OP_LBU) || (cur_op == OP_SB);
      is_half = (cur_op == OP_LH) || (cur_op == OP_LHU) || (cur_op == OP_SH);
      is_mem  = is_load || cur_st;
`ifdef KAMUS_MISALIGN_TRAP_EN
      mis = is_mem && ((is_half && a[0]) || (!is_byte && !is_half && (a != 2'b00)));
`else
      mis = 1'b0;
`endif

      be_n    = 4'b1111;
      wdata_n = cur_rs2;
      if (cur_st && is_byte) begin
         be_n    = 4'b0001 << a;
         wdata_n = {4{cur_rs2[7:0]}};
      end else if (cur_st && is_half) begin
         be_n    = a[1] ? 4'b1100 : 4'b0011;
         wdata_n = {2{cur_rs2[15:0]}};
      end

      shifted = l1d_rdata_i >> {a, 3'b000};
      half_v  = a[1] ? l1d_rdata_i[31:16] : l1d_rdata_i[15:0];
      case (cur_op)
         OP_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  ext = {24'd0, shifted[7:0]};
         OP_LH:   ext = {{16{half_v[15]}}, half_v};
         OP_LHU:  ext = {16'd0, half_v};
         default: ext = l1d_rdata_i;
      endcase

      state_d = state_q;
      op_d = op_q; ex_d = ex_q; rs2_d = rs2_q; rd_d = rd_q;
      st_d = st_q; rf_d = rf_q; sel_d = sel_q;
      req_d = req_q; we_d = we_q; addr_d = addr_q; be_d = be_q; wdata_d = wdata_q;
      wb_ex_d = wb_ex_q; ld_d = ld_q; wb_rd_d = wb_rd_q;
      wb_rf_d = wb_rf_q; wb_sel_d = wb_sel_q; mis_d = mis_q;
      done = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               op_d = operation_i; ex_d = ex_i; rs2_d = rs2_data_i; rd_d = rd_addr_i;
               st_d = l1d_wr_en_i; rf_d = regfile_wr_en_i; sel_d = wb_mux_sel_i;
               if (is_mem && !mis) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  we_d    = cur_st;
                  addr_d  = {cur_ex[31:2], 2'b00};
                  be_d    = be_n;
                  wdata_d = wdata_n;
               end else begin
                  state_d = DONE;
                  done    = 1'b1;
               end
            end
         end
         REQ: begin
            // rvalid arriving alongside the grant belongs to no access and is dropped.
            if (l1d_gnt_i) begin
               req_d = 1'b0;
               if (cur_st) begin
                  state_d = DONE;
                  done    = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (l1d_rvalid_i) begin
               state_d = DONE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = done;
      if (done) begin
         wb_ex_d  = cur_ex;
         ld_d     = (state_q == WAIT) ? ext : 32'd0;
         wb_rd_d  = cur_rd;
         wb_rf_d  = cur_rf && !mis;
         wb_sel_d = cur_sel;
         mis_d    = mis;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         op_q <= 6'd0; ex_q <= 32'd0; rs2_q <= 32'd0; rd_q <= 5'd0;
         st_q <= 1'b0; rf_q <= 1'b0; sel_q <= 2'd0;
         req_q <= 1'b0; we_q <= 1'b0; addr_q <= 32'd0; be_q <= 4'd0; wdata_q <= 32'd0;
         valid_q <= 1'b0; wb_ex_q <= 32'd0; ld_q <= 32'd0; wb_rd_q <= 5'd0;
         wb_rf_q <= 1'b0; wb_sel_q <= 2'd0; mis_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d; ex_q <= ex_d; rs2_q <= rs2_d; rd_q <= rd_d;
         st_q <= st_d; rf_q <= rf_d; sel_q <= sel_d;
         req_q <= req_d; we_q <= we_d; addr_q <= addr_d; be_q <= be_d; wdata_q <= wdata_d;
         valid_q <= valid_d; wb_ex_q <= wb_ex_d; ld_q <= ld_d; wb_rd_q <= wb_rd_d;
         wb_rf_q <= wb_rf_d; wb_sel_q <= wb_sel_d; mis_q <= mis_d;
      end
   end

   assign ready_o         = (state_q == IDLE) && !rst_i;
   assign l1d_req_o       = req_q;
   assign l1d_we_o        = we_q;
   assign l1d_addr_o      = addr_q;
   assign l1d_be_o        = be_q;
   assign l1d_wdata_o     = wdata_q;
   assign valid_o         = valid_q;
   assign ex_o            = wb_ex_q;
   assign load_data_o     = ld_q;
   assign rd_addr_o       = wb_rd_q;
   assign regfile_wr_en_o = wb_rf_q;
   assign wb_mux_sel_o    = wb_sel_q;
   assign misaligned_o    = mis_q;

endmodule

// File: tb/tb_kamus_mem.sv
// tb/tb_kamus_mem.sv - directed bench for kamus_mem with immediate-assertion checks.
module tb_kamus_mem;

   localparam logic [5:0] OP_ADD = 6'd0;
   localparam logic [5:0] OP_LB  = 6'd1;
   localparam logic [5:0] OP_LBU = 6'd2;
   localparam logic [5:0] OP_LH  = 6'd3;
   localparam logic [5:0] OP_LHU = 6'd4;
   localparam logic [5:0] OP_LW  = 6'd5;
   localparam logic [5:0] OP_SB  = 6'd6;
   localparam logic [5:0] OP_SH  = 6'd7;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i, ready_o;
   logic [5:0]  operation_i;
   logic [31:0] ex_i, rs2_data_i;
   logic [4:0]  rd_addr_i;
   logic        l1d_wr_en_i, regfile_wr_en_i;
   logic [1:0]  wb_mux_sel_i;
   logic        l1d_req_o, l1d_we_o;
   logic [31:0] l1d_addr_o;
   logic [3:0]  l1d_be_o;
   logic [31:0] l1d_wdata_o;
   logic        l1d_gnt_i, l1d_rvalid_i;
   logic [31:0] l1d_rdata_i;
   logic        valid_o;
   logic [31:0] ex_o, load_data_o;
   logic [4:0]  rd_addr_o;
   logic        regfile_wr_en_o;
   logic [1:0]  wb_mux_sel_o;
   logic        misaligned_o;

   int checks = 0;
   int errors = 0;

   kamus_mem dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .operation_i(operation_i), .ex_i(ex_i), .rs2_data_i(rs2_data_i),
      .rd_addr_i(rd_addr_i), .l1d_wr_en_i(l1d_wr_en_i),
      .regfile_wr_en_i(regfile_wr_en_i), .wb_mux_sel_i(wb_mux_sel_i),
      .l1d_req_o(l1d_req_o), .l1d_we_o(l1d_we_o), .l1d_addr_o(l1d_addr_o),
      .l1d_be_o(l1d_be_o), .l1d_wdata_o(l1d_wdata_o), .l1d_gnt_i(l1d_gnt_i),
      .l1d_rvalid_i(l1d_rvalid_i), .l1d_rdata_i(l1d_rdata_i), .valid_o(valid_o),
      .ex_o(ex_o), .load_data_o(load_data_o), .rd_addr_o(rd_addr_o),
      .regfile_wr_en_o(regfile_wr_en_o), .wb_mux_sel_o(wb_mux_sel_o),
      .misaligned_o(misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic st, input logic rf);
      valid_i = 1'b1; operation_i = op; ex_i = ex; rs2_data_i = rs2;
      rd_addr_i = rd; l1d_wr_en_i = st; regfile_wr_en_i = rf; wb_mux_sel_i = 2'd1;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic load_test(input string tag, input logic [5:0] op, input logic [31:0] ex,
                            input logic [31:0] rdata, input logic [31:0] exp);
      issue(op, ex, 32'd0, 5'd7, 1'b0, 1'b1);
      chk({tag, "_req"}, {31'd0, l1d_req_o}, 32'd1);
      chk({tag, "_we"}, {31'd0, l1d_we_o}, 32'd0);
      chk({tag, "_be"}, {28'd0, l1d_be_o}, 32'hF);
      chk({tag, "_addr"}, l1d_addr_o, {ex[31:2], 2'b00});
      l1d_gnt_i = 1'b1;
      tick();
      l1d_gnt_i = 1'b0;
      chk({tag, "_wait_req"}, {31'd0, l1d_req_o}, 32'd0);
      l1d_rvalid_i = 1'b1; l1d_rdata_i = rdata;
      tick();
      l1d_rvalid_i = 1'b0;
      chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      chk({tag, "_data"}, load_data_o, exp);
      chk({tag, "_rd"}, {27'd0, rd_addr_o}, 32'd7);
      tick();
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; operation_i = OP_ADD; ex_i = '0; rs2_data_i = '0;
      rd_addr_i = '0; l1d_wr_en_i = 1'b0; regfile_wr_en_i = 1'b0; wb_mux_sel_i = '0;
      l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0; l1d_rdata_i = '0;
      tick(); tick();
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_req", {31'd0, l1d_req_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_ex", ex_o, 32'd0);
      rst_i = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
      chk("post_rst_mis", {31'd0, misaligned_o}, 32'd0);

      // ADD pass-through
      issue(OP_ADD, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b1);
      chk("add_valid", {31'd0, valid_o}, 32'd1);
      chk("add_ex", ex_o, 32'h1234);
      chk("add_rd", {27'd0, rd_addr_o}, 32'd5);
      chk("add_rf", {31'd0, regfile_wr_en_o}, 32'd1);
      chk("add_sel", {30'd0, wb_mux_sel_o}, 32'd1);
      chk("add_req", {31'd0, l1d_req_o}, 32'd0);
      chk("add_ready", {31'd0, ready_o}, 32'd0);
      chk("add_ld", load_data_o, 32'd0);
      tick();
      chk("add_valid_pulse", {31'd0, valid_o}, 32'd0);
      chk("add_ready_back", {31'd0, ready_o}, 32'd1);
      chk("add_ex_hold", ex_o, 32'h1234);

      // SB at 0x1003, grant in the second request cycle
      issue(OP_SB, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b1, 1'b0);
      chk("sb_req1", {31'd0, l1d_req_o}, 32'd1);
      chk("sb_we", {31'd0, l1d_we_o}, 32'd1);
      chk("sb_addr", l1d_addr_o, 32'h1000);
      chk("sb_be", {28'd0, l1d_be_o}, 32'h8);
      chk("sb_wdata", l1d_wdata_o, 32'hDDDDDDDD);
      chk("sb_ready", {31'd0, ready_o}, 32'd0);
      tick();
      chk("sb_req2", {31'd0, l1d_req_o}, 32'd1);
      chk("sb_novalid", {31'd0, valid_o}, 32'd0);
      l1d_gnt_i = 1'b1;
      tick();
      l1d_gnt_i = 1'b0;
      chk("sb_valid", {31'd0, valid_o}, 32'd1);
      chk("sb_req_off", {31'd0, l1d_req_o}, 32'd0);
      chk("sb_rf", {31'd0, regfile_wr_en_o}, 32'd0);
      chk("sb_ex", ex_o, 32'h1003);
      tick();
      chk("sb_ready_back", {31'd0, ready_o}, 32'd1);

      // SH upper half, immediate grant
      issue(OP_SH, 32'h1002, 32'h1234ABCD, 5'd0, 1'b1, 1'b0);
      chk("sh_be", {28'd0, l1d_be_o}, 32'hC);
      chk("sh_wdata", l1d_wdata_o, 32'hABCDABCD);
      l1d_gnt_i = 1'b1;
      tick();
      l1d_gnt_i = 1'b0;
      chk("sh_valid", {31'd0, valid_o}, 32'd1);
      tick();

      load_test("lb",  OP_LB,  32'h2002, 32'h00F10000, 32'hFFFFFFF1);
      load_test("lbu", OP_LBU, 32'h2002, 32'h00F10000, 32'h000000F1);
      load_test("lh",  OP_LH,  32'h2002, 32'h80010000, 32'hFFFF8001);
      load_test("lhu", OP_LHU, 32'h2002, 32'h80010000, 32'h00008001);
      load_test("lb0", OP_LB,  32'h2000, 32'h0000007F, 32'h0000007F);
      load_test("lw",  OP_LW,  32'h2004, 32'hDEADBEEF, 32'hDEADBEEF);

      // Load latency: grant N+1 (with a stray rvalid), rvalid N+4, valid_o N+5
      issue(OP_LW, 32'h4000, 32'd0, 5'd9, 1'b0, 1'b1);
      chk("lat_n1_ready", {31'd0, ready_o}, 32'd0);
      l1d_gnt_i = 1'b1; l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h55555555;
      tick();
      l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
      chk("lat_n2_valid", {31'd0, valid_o}, 32'd0);
      chk("lat_n2_ready", {31'd0, ready_o}, 32'd0);
      tick();
      chk("lat_n3_valid", {31'd0, valid_o}, 32'd0);
      tick();
      chk("lat_n4_ready", {31'd0, ready_o}, 32'd0);
      l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h0BADF00D;
      tick();
      l1d_rvalid_i = 1'b0;
      chk("lat_n5_valid", {31'd0, valid_o}, 32'd1);
      chk("lat_n5_ready", {31'd0, ready_o}, 32'd0);
      chk("lat_n5_data", load_data_o, 32'h0BADF00D);
      tick();
      chk("lat_n6_ready", {31'd0, ready_o}, 32'd1);
      chk("lat_n6_valid", {31'd0, valid_o}, 32'd0);

      // Reset while the request is outstanding drops l1d_req_o at once
      issue(OP_LW, 32'h5000, 32'd0, 5'd3, 1'b0, 1'b1);
      chk("rreq_req", {31'd0, l1d_req_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      chk("rreq_req_async", {31'd0, l1d_req_o}, 32'd0);
      tick();
      rst_i = 1'b0;

      // Reset in WAIT, then a late rvalid
      issue(OP_LW, 32'h5000, 32'd0, 5'd3, 1'b0, 1'b1);
      l1d_gnt_i = 1'b1;
      tick();
      l1d_gnt_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("rwait_req", {31'd0, l1d_req_o}, 32'd0);
      chk("rwait_valid", {31'd0, valid_o}, 32'd0);
      chk("rwait_ex", ex_o, 32'd0);
      tick();
      rst_i = 1'b0;
      l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h12345678;
      tick();
      l1d_rvalid_i = 1'b0;
      chk("late_rvalid_valid", {31'd0, valid_o}, 32'd0);
      chk("late_rvalid_ready", {31'd0, ready_o}, 32'd1);
      tick();
      chk("late_rvalid_valid2", {31'd0, valid_o}, 32'd0);

`ifdef KAMUS_MISALIGN_TRAP_EN
      issue(OP_LW, 32'h3001, 32'd0, 5'd4, 1'b0, 1'b1);
      chk("mis_req", {31'd0, l1d_req_o}, 32'd0);
      chk("mis_valid", {31'd0, valid_o}, 32'd1);
      chk("mis_flag", {31'd0, misaligned_o}, 32'd1);
      chk("mis_ex", ex_o, 32'h3001);
      chk("mis_rf", {31'd0, regfile_wr_en_o}, 32'd0);
      tick();
`else
      load_test("lw_unal", OP_LW, 32'h3001, 32'h11223344, 32'h11223344);
      chk("unal_mis", {31'd0, misaligned_o}, 32'd0);
      chk("unal_rf", {31'd0, regfile_wr_en_o}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
